prbs_checker: RTL

//   Self-synchronising PRBS checker for the noise tester. Compares the received
//   bit stream against a locally regenerated PRBS sequence and emits one error

---
 rtl/prbs_checker.sv | 138 +++++++++++++
 1 files changed

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker. Loads the shift register from received
// data until enough consecutive bits match the predicted PRBS. It then runs
// free and flags every mismatch. It drops lock when too many errors fall
// within one checking window.
module prbs_checker #(
   parameter int LFSR_WIDTH  = 7,
   parameter int TAP_A       = 7,
   parameter int TAP_B       = 6,
   parameter int LOCK_COUNT  = 16,
   parameter int LOSS_WINDOW = 64,
   parameter int LOSS_THRESH = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic in_valid,
   input  logic rx_bit,
   output logic lock,
   output logic err_out,
   output logic err_valid,
   output logic lock_lost
);

   localparam int FILL_W  = $clog2(LFSR_WIDTH + 1);
   localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
   localparam int WIN_W   = $clog2(LOSS_WINDOW);
   localparam int ERR_W   = $clog2(LOSS_THRESH + 1);

   typedef enum logic {
      SEARCH,
      LOCKED
   } state_t;

   state_t                  state_q, state_d;
   logic [LFSR_WIDTH-1:0]   sr_q, sr_d;
   logic [FILL_W-1:0]       fill_q, fill_d;
   logic [MATCH_W-1:0]      match_q, match_d;
   logic [WIN_W-1:0]        win_q, win_d;
   logic [ERR_W-1:0]        errc_q, errc_d;
   logic                    err_out_d, err_valid_d, lock_lost_d;
   logic                    predicted;
   logic                    mismatch;

   assign predicted = sr_q[TAP_A-1] ^ sr_q[TAP_B-1];
   assign mismatch  = rx_bit ^ predicted;
   assign lock      = (state_q == LOCKED);

   // State register plus all counters and registered outputs.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples its pre-edge value regardless of statement order.
      if (reset) begin
         state_q   <= SEARCH;
         sr_q      <= '0;
         fill_q    <= '0;
         match_q   <= '0;
         win_q     <= '0;
         errc_q    <= '0;
         err_out   <= 1'b0;
         err_valid <= 1'b0;
         lock_lost <= 1'b0;
      end else begin
         state_q   <= state_d;
         sr_q      <= sr_d;
         fill_q    <= fill_d;
         match_q   <= match_d;
         win_q     <= win_d;
         errc_q    <= errc_d;
         err_out   <= err_out_d;
         err_valid <= err_valid_d;
         lock_lost <= lock_lost_d;
      end
   end

   // Next-state, counter updates and output decode for one received bit.
   always_comb begin
      // NOTE: every signal gets a default before any branch, so no path
      // leaves one unassigned and no latch is inferred.
      state_d     = state_q;
      sr_d        = sr_q;
      fill_d      = fill_q;
      match_d     = match_q;
      win_d       = win_q;
      errc_d      = errc_q;
      err_out_d   = 1'b0;
      err_valid_d = 1'b0;
      lock_lost_d = 1'b0;

      if (in_valid) begin
         case (state_q)
            SEARCH: begin
               sr_d = {sr_q[LFSR_WIDTH-2:0], rx_bit};
               if (fill_q < FILL_W'(LFSR_WIDTH)) begin
                  fill_d = fill_q + 1'b1;
               end else if (!mismatch && (sr_q != '0)) begin
                  // An all-zero register predicts zero forever, so it never
                  // counts toward lock.
                  if (match_q == MATCH_W'(LOCK_COUNT - 1)) begin
                     state_d = LOCKED;
                     match_d = '0;
                     win_d   = '0;
                     errc_d  = '0;
                  end else begin
                     match_d = match_q + 1'b1;
                  end
               end else begin
                  match_d = '0;
               end
            end

            LOCKED: begin
               // Free-running: a corrupted rx bit never enters the register.
               sr_d        = {sr_q[LFSR_WIDTH-2:0], predicted};
               err_out_d   = mismatch;
               err_valid_d = 1'b1;
               if (mismatch && (errc_q == ERR_W'(LOSS_THRESH - 1))) begin
                  // Loss wins over a window wrap on the same bit. The register
                  // is kept, but fill restarts and forces a full reload.
                  state_d     = SEARCH;
                  lock_lost_d = 1'b1;
                  fill_d      = '0;
                  match_d     = '0;
                  win_d       = '0;
                  errc_d      = '0;
               end else if (win_q == WIN_W'(LOSS_WINDOW - 1)) begin
                  win_d  = '0;
                  errc_d = '0;
               end else begin
                  win_d  = win_q + 1'b1;
                  errc_d = errc_q + ERR_W'(mismatch);
               end
            end

            default: state_d = SEARCH;
         endcase
      end
   end

endmodule
